// File: rtl/mem_pager.sv
// Paging unit for the 6801 bus: maps CPU address windows onto external SRAM pages,
// with write-protect fault capture and wait-state generation through the hold line.
module mem_pager #(
   parameter int unsigned WINDOWS     = 4,
   parameter int unsigned WIN_BITS    = 13,
   parameter int unsigned WIN_FIRST   = 2,
   parameter int unsigned PAGE_BITS   = 6,
   parameter int unsigned EXT_AW      = 19,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        AD,
   input  logic [7:0]        DI,
   output logic [7:0]        DO,
   input  logic              rw,
   input  logic              cs,
   input  logic [15:0]       cpu_ad,
   input  logic              vma,
   output logic [EXT_AW-1:0] ext_ad,
   output logic              ext_hit,
   output logic              ext_wblock,
   output logic              bram_disable,
   output logic              irq,
   output logic              hold
);

   localparam int unsigned NSLOT = 8;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   logic                 r_en  [NSLOT];
   logic                 r_wp  [NSLOT];
   logic [PAGE_BITS-1:0] r_pg  [NSLOT];
   logic                 r_bd;
   logic                 r_ie;
   logic                 r_fault;
   logic [2:0]           r_fwin;
   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [15:0]          r_lat_ad;

   logic [16:0]          w_off;
   logic [2:0]           w_idx;
   logic                 w_inwin;
   logic                 w_hit;
   logic                 w_acc;
   logic                 w_wr;
   logic                 w_wr_page;

   // Window decode; below-range addresses wrap to a large offset and miss
   assign w_off     = 17'(cpu_ad >> WIN_BITS) - 17'(WIN_FIRST);
   assign w_idx     = 3'(w_off);
   assign w_inwin   = (w_off < 17'(WINDOWS));
   assign w_hit     = w_inwin && r_en[w_idx];
   assign w_acc     = w_hit && vma;
   assign w_wr      = cs && !rw;
   assign w_wr_page = w_wr && (AD < 5'(WINDOWS));

   assign ext_hit      = w_hit;
   assign ext_ad       = w_hit ? EXT_AW'({r_pg[w_idx], cpu_ad[WIN_BITS-1:0]}) : EXT_AW'(cpu_ad);
   assign ext_wblock   = w_hit && vma && !rw && r_wp[w_idx];
   assign irq          = r_fault && r_ie;
   assign bram_disable = r_bd;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NSLOT; i++) begin
            r_en[i] <= 1'b0;
            r_wp[i] <= 1'b0;
            r_pg[i] <= '0;
         end
      end else if (w_wr_page) begin
         r_en[AD[2:0]] <= DI[7];
         r_wp[AD[2:0]] <= DI[6];
         r_pg[AD[2:0]] <= DI[PAGE_BITS-1:0];
      end
   end

   // A fault in the same cycle as a FAULT-clear write takes priority
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bd    <= 1'b0;
         r_ie    <= 1'b0;
         r_fault <= 1'b0;
         r_fwin  <= '0;
      end else begin
         if (w_wr && AD == 5'd8) begin
            r_bd <= DI[0];
            r_ie <= DI[1];
            if (DI[7]) r_fault <= 1'b0;
         end
         if (ext_wblock) begin
            r_fault <= 1'b1;
            r_fwin  <= w_idx;
         end
      end
   end

   always_comb begin
      DO = '0;
      if (cs && rw) begin
         if (AD < 5'(WINDOWS))
            DO = {r_en[AD[2:0]], r_wp[AD[2:0]], 6'(r_pg[AD[2:0]])};
         else if (AD == 5'd8)
            DO = {r_fault, 5'd0, r_ie, r_bd};
         else if (AD == 5'd9)
            DO = {5'd0, r_fwin};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // The access cycle is the first held cycle; WAIT supplies the remaining ones
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_acc && WAIT_STATES != 0)
                    w_state_nxt = (WAIT_STATES > 1) ? S_WAIT : S_DONE;
         S_WAIT: if (r_cnt == CNT_W'(1)) w_state_nxt = S_DONE;
         S_DONE: if (!w_acc || cpu_ad != r_lat_ad) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      hold = 1'b0;
      case (r_state)
         S_IDLE:  hold = w_acc && (WAIT_STATES != 0);
         S_WAIT:  hold = 1'b1;
         default: hold = 1'b0;
      endcase
   end

   // r_cnt holds the held cycles still owed after the current one
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_lat_ad <= '0;
      end else if (r_state == S_IDLE && hold) begin
         r_cnt    <= CNT_W'(WAIT_STATES - 1);
         r_lat_ad <= cpu_ad;
      end else if (r_state == S_WAIT) begin
         r_cnt    <= r_cnt - CNT_W'(1);
      end
   end

endmodule
